// File: rtl/icache_resp.sv
// rtl/icache_resp.sv - direct-mapped one-word-line instruction cache with single-word refill
//
// Purpose: serves fetch word addresses combinationally on a hit; on a miss stalls
// fetch, refills one word over a req/ack handshake, then serves the hit.
// Optional feature macro: ICACHE_FLUSH_EN (adds i_flush, clears all valid bits).
//
// Ports:
//   i_clk       clock, rising edge
//   i_arst_n    asynchronous active-low reset
//   i_pc        fetch word address
//   o_instr     instruction for i_pc (0 / NOP when not a hit), combinational
//   o_stall     high while i_pc misses or a refill is in flight, combinational
//   o_mem_req   refill request, registered
//   o_mem_addr  refill word address, registered
//   i_mem_ack   single-cycle refill data-valid pulse
//   i_mem_data  refill word, sampled with i_mem_ack
//   i_flush     (ICACHE_FLUSH_EN only) invalidate all lines at the next edge

module icache_resp #(
  parameter int INSTR_ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH      = 32,
  parameter int INDEX_WIDTH      = 4,
  localparam int PC_WIDTH        = INSTR_ADDR_WIDTH - 2
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic [PC_WIDTH-1:0]    i_pc,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_stall,
  output logic                   o_mem_req,
  output logic [PC_WIDTH-1:0]    o_mem_addr,
  input  logic                   i_mem_ack,
`ifdef ICACHE_FLUSH_EN
  input  logic                   i_flush,
`endif
  input  logic [INSTR_WIDTH-1:0] i_mem_data
);

  localparam int TAG_WIDTH = PC_WIDTH - INDEX_WIDTH;
  localparam int LINES     = 2 ** INDEX_WIDTH;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                 state;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [INSTR_WIDTH-1:0] data_mem [LINES];

  logic [INDEX_WIDTH-1:0] index;
  logic [TAG_WIDTH-1:0]   tag;
  logic [INDEX_WIDTH-1:0] fill_index;
  logic [TAG_WIDTH-1:0]   fill_tag;
  logic                   hit;
  logic                   fill_we;

  assign index      = i_pc[INDEX_WIDTH-1:0];
  assign tag        = i_pc[PC_WIDTH-1:INDEX_WIDTH];
  assign fill_index = o_mem_addr[INDEX_WIDTH-1:0];
  assign fill_tag   = o_mem_addr[PC_WIDTH-1:INDEX_WIDTH];

  // A hit is only reported in IDLE so the pipeline stays stalled for the whole
  // refill even if fetch redirects i_pc to a resident line meanwhile.
  assign hit     = (state == IDLE) && valid[index] && (tag_mem[index] == tag);
  assign o_instr = hit ? data_mem[index] : '0;
  assign o_stall = !hit;

  // Acks outside WAIT are stray and must never touch the arrays.
  assign fill_we = (state == WAIT) && i_mem_ack;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state      <= IDLE;
      valid      <= '0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            state      <= WAIT;
            o_mem_req  <= 1'b1;
            o_mem_addr <= i_pc;
          end
        end
        WAIT: begin
          // Address is held from the miss, so a redirect during WAIT still
          // completes the original refill.
          if (i_mem_ack) begin
            valid[fill_index] <= 1'b1;
            o_mem_req         <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef ICACHE_FLUSH_EN
      // Placed last so a flush overrides a same-edge refill valid set.
      if (i_flush) valid <= '0;
`endif
    end
  end

  // Tag/data need no reset: valid gates every use of them.
  always_ff @(posedge i_clk) begin
    if (fill_we) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= i_mem_data;
    end
  end

endmodule

// File: tb/tb_icache_resp.sv
// tb/tb_icache_resp.sv - scoreboard testbench for icache_resp
module tb_icache_resp;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int XW = 4;
  localparam int PW = AW - 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] pc;
  logic [IW-1:0] o_instr;
  logic          o_stall;
  logic          o_mem_req;
  logic [PW-1:0] o_mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_data;
`ifdef ICACHE_FLUSH_EN
  logic          flush;
`endif

  int checks   = 0;
  int failures = 0;
  logic [IW-1:0] sb [$];

  always #5 clk = ~clk;

  icache_resp #(.INSTR_ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .INDEX_WIDTH(XW)) dut (
    .i_clk      (clk),
    .i_arst_n   (rst_n),
    .i_pc       (pc),
    .o_instr    (o_instr),
    .o_stall    (o_stall),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_ack  (mem_ack),
`ifdef ICACHE_FLUSH_EN
    .i_flush    (flush),
`endif
    .i_mem_data (mem_data)
  );

  // Backing instruction memory contents; address 0 holds 0x2408_0005.
  function automatic logic [IW-1:0] mem_model(input logic [PW-1:0] a);
    return 32'h2408_0005 + ({2'b00, a} * 32'h0101_0101);
  endfunction

  // Entered in the low clock phase; presents a missing pc, answers the request
  // after 'delay' wait cycles and checks the resulting hit.
  task automatic do_miss(input logic [PW-1:0] a, input int delay);
    logic [IW-1:0] exp;
    pc = a; #1;
    checks++;
    if (o_stall !== 1'b1 || o_instr !== '0) begin
      failures++; $display("FAIL miss_out pc=%h got stall=%b instr=%h exp stall=1 instr=0", a, o_stall, o_instr);
    end
    @(negedge clk); #1;
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== a) begin
      failures++; $display("FAIL req_rise got req=%b addr=%h exp req=1 addr=%h", o_mem_req, o_mem_addr, a);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk); #1;
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== a || o_stall !== 1'b1) begin
        failures++; $display("FAIL wait_hold cyc=%0d got req=%b addr=%h stall=%b exp 1 %h 1", i, o_mem_req, o_mem_addr, o_stall, a);
      end
    end
    mem_ack = 1'b1; mem_data = mem_model(a); sb.push_back(mem_model(a));
    @(negedge clk); mem_ack = 1'b0; #1;
    exp = sb.pop_front();
    checks++;
    if (o_stall !== 1'b0 || o_mem_req !== 1'b0 || o_instr !== exp) begin
      failures++; $display("FAIL refill_hit pc=%h got stall=%b req=%b instr=%h exp 0 0 %h", a, o_stall, o_mem_req, o_instr, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc = '0; mem_ack = 1'b0; mem_data = '0;
`ifdef ICACHE_FLUSH_EN
    flush = 1'b0;
`endif
    @(negedge clk); #1;
    checks++;
    if (o_stall !== 1'b1 || o_instr !== '0 || o_mem_req !== 1'b0 || o_mem_addr !== '0) begin
      failures++; $display("FAIL reset got stall=%b instr=%h req=%b addr=%h exp 1 0 0 0", o_stall, o_instr, o_mem_req, o_mem_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_miss();
    do_miss('0, 0);
    checks++;
    if (o_instr !== 32'h2408_0005) begin
      failures++; $display("FAIL first_data got %h exp 24080005", o_instr);
    end
  endtask

  task automatic test_fill_replay();
    logic [IW-1:0] exp;
    for (int i = 1; i < 16; i++) do_miss(PW'(i), 0);
    for (int i = 0; i < 16; i++) begin
      pc = PW'(i); #1;
      sb.push_back(mem_model(PW'(i)));
      exp = sb.pop_front();
      checks++;
      if (o_stall !== 1'b0 || o_mem_req !== 1'b0 || o_instr !== exp) begin
        failures++; $display("FAIL replay pc=%h got stall=%b req=%b instr=%h exp 0 0 %h", pc, o_stall, o_mem_req, o_instr, exp);
      end
      @(negedge clk); #1;
    end
    checks++;
    if (o_mem_req !== 1'b0) begin
      failures++; $display("FAIL replay_noreq got req=%b exp 0", o_mem_req);
    end
  endtask

  task automatic test_conflict();
    do_miss(PW'('h13), 0);
    do_miss(PW'('h03), 0);
  endtask

  task automatic test_delay_and_stray();
    logic [IW-1:0] exp;
    do_miss(PW'('h25), 5);
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    @(negedge clk); mem_ack = 1'b0; #1;
    sb.push_back(mem_model(PW'('h25)));
    exp = sb.pop_front();
    checks++;
    if (o_stall !== 1'b0 || o_mem_req !== 1'b0 || o_instr !== exp) begin
      failures++; $display("FAIL stray_ack got stall=%b req=%b instr=%h exp 0 0 %h", o_stall, o_mem_req, o_instr, exp);
    end
  endtask

  task automatic test_redirect();
    logic [IW-1:0] exp;
    pc = PW'('h20); #1;
    @(negedge clk); #1;
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== PW'('h20)) begin
      failures++; $display("FAIL redir_req got req=%b addr=%h exp 1 20", o_mem_req, o_mem_addr);
    end
    pc = PW'('h40); #1;
    checks++;
    if (o_stall !== 1'b1 || o_mem_addr !== PW'('h20)) begin
      failures++; $display("FAIL redir_wait got stall=%b addr=%h exp 1 20", o_stall, o_mem_addr);
    end
    mem_ack = 1'b1; mem_data = mem_model(PW'('h20)); sb.push_back(mem_model(PW'('h20)));
    @(negedge clk); mem_ack = 1'b0;
    pc = PW'('h20); #1;
    exp = sb.pop_front();
    checks++;
    if (o_stall !== 1'b0 || o_instr !== exp) begin
      failures++; $display("FAIL redir_line0 got stall=%b instr=%h exp 0 %h", o_stall, o_instr, exp);
    end
    pc = PW'('h40); #1;
    checks++;
    if (o_stall !== 1'b1 || o_mem_req !== 1'b0) begin
      failures++; $display("FAIL redir_newmiss got stall=%b req=%b exp 1 0", o_stall, o_mem_req);
    end
    @(negedge clk); #1;
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== PW'('h40)) begin
      failures++; $display("FAIL redir_req2 got req=%b addr=%h exp 1 40", o_mem_req, o_mem_addr);
    end
    mem_ack = 1'b1; mem_data = mem_model(PW'('h40)); sb.push_back(mem_model(PW'('h40)));
    @(negedge clk); mem_ack = 1'b0; #1;
    exp = sb.pop_front();
    checks++;
    if (o_stall !== 1'b0 || o_instr !== exp) begin
      failures++; $display("FAIL redir_hit2 got stall=%b instr=%h exp 0 %h", o_stall, o_instr, exp);
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [IW-1:0] exp;
    pc = PW'('h33); #1;
    @(negedge clk); #1;
    checks++;
    if (o_mem_req !== 1'b1) begin
      failures++; $display("FAIL mid_req got req=%b exp 1", o_mem_req);
    end
    rst_n = 1'b0; pc = PW'('h25); #1;
    checks++;
    if (o_mem_req !== 1'b0 || o_stall !== 1'b1 || o_instr !== '0) begin
      failures++; $display("FAIL mid_reset got req=%b stall=%b instr=%h exp 0 1 0", o_mem_req, o_stall, o_instr);
    end
    @(negedge clk);
    pc = PW'('h33); rst_n = 1'b1; mem_ack = 1'b1; mem_data = 32'hBAD0_BAD0;
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== PW'('h33) || o_stall !== 1'b1) begin
      failures++; $display("FAIL late_ack got req=%b addr=%h stall=%b exp 1 33 1", o_mem_req, o_mem_addr, o_stall);
    end
    mem_ack = 1'b1; mem_data = mem_model(PW'('h33)); sb.push_back(mem_model(PW'('h33)));
    @(negedge clk); mem_ack = 1'b0; #1;
    exp = sb.pop_front();
    checks++;
    if (o_stall !== 1'b0 || o_instr !== exp) begin
      failures++; $display("FAIL post_reset_hit got stall=%b instr=%h exp 0 %h", o_stall, o_instr, exp);
    end
  endtask

`ifdef ICACHE_FLUSH_EN
  task automatic test_flush();
    do_miss(PW'('h05), 0);
    pc = PW'('h06); #1;
    @(negedge clk); #1;
    mem_ack = 1'b1; flush = 1'b1; mem_data = mem_model(PW'('h06));
    @(negedge clk); mem_ack = 1'b0; flush = 1'b0; #1;
    checks++;
    if (o_stall !== 1'b1 || o_mem_req !== 1'b0) begin
      failures++; $display("FAIL flush_06 got stall=%b req=%b exp 1 0", o_stall, o_mem_req);
    end
    pc = PW'('h05); #1;
    checks++;
    if (o_stall !== 1'b1) begin
      failures++; $display("FAIL flush_05 got stall=%b exp 1", o_stall);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_miss();
    test_fill_replay();
    test_conflict();
    test_delay_and_stray();
    test_redirect();
    test_reset_mid_refill();
`ifdef ICACHE_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_resp.md
# icache_resp

Direct-mapped instruction cache that answers the fetch stage's word-address requests and returns the instruction in the same cycle on a hit. On a miss it drives a stall to the pipeline, refills one word from external instruction memory over a req/ack handshake, then serves the hit. It sits between the fetch stage (the PC consumer of `o_instr`) and the external instruction memory.

## Interface
- `INSTR_ADDR_WIDTH`, 32, byte address width; word address (PC) width is `INSTR_ADDR_WIDTH-2`.
- `INSTR_WIDTH`, 32, instruction/data word width.
- `INDEX_WIDTH`, 4, line index bits; `2**INDEX_WIDTH` one-word lines; tag width is `PC_WIDTH-INDEX_WIDTH`.

- `i_clk` in 1: clock, all state updates on rising edge.
- `i_arst_n` in 1: asynchronous active-low reset.
- `i_pc` in PC_WIDTH: word address from fetch (fetch's current PC).
- `o_instr` out INSTR_WIDTH: instruction for `i_pc`; combinational.
- `o_stall` out 1: high while `i_pc` misses or a refill is in flight; combinational.
- `o_mem_req` out 1: refill request, registered.
- `o_mem_addr` out PC_WIDTH: refill word address, registered.
- `i_mem_ack` in 1: single-cycle pulse, data valid.
- `i_mem_data` in INSTR_WIDTH: refill word, sampled when `i_mem_ack`=1.

## Operation
- Storage: per line a valid bit, tag and data word, held in flops (combinational read).
- Index = `i_pc[INDEX_WIDTH-1:0]`; tag = `i_pc[PC_WIDTH-1:INDEX_WIDTH]`.
- Hit = state IDLE and valid[index] and tag match. On hit: `o_instr`=data[index], `o_stall`=0.
- Not hit: `o_instr`=0 (NOP), `o_stall`=1.
- FSM states: IDLE, WAIT.
  - IDLE, miss: next edge → WAIT; `o_mem_req`<=1, `o_mem_addr`<=`i_pc`.
  - IDLE, hit: stay.
  - WAIT: `o_mem_req`, `o_mem_addr` held stable; `o_stall`=1 regardless of `i_pc`.
  - WAIT, `i_mem_ack`=1: at that edge write data/tag (from `o_mem_addr`)/valid=1 to line `o_mem_addr[INDEX_WIDTH-1:0]`; `o_mem_req`<=0; → IDLE.
- `i_mem_ack` in IDLE is ignored (no write, no state change).
- `i_pc` change during WAIT (e.g. exception redirect): refill for latched address completes and is written; IDLE then re-evaluates new `i_pc` (may miss again).
- Conflict replacement: refill overwrites the line unconditionally.

## Timing
- Hit: zero-cycle latency; `o_instr` valid same cycle as `i_pc`.
- Miss with ack in first WAIT cycle: miss cycle C0, req C1 (ack), hit C2; penalty = 2 cycles + memory wait cycles.
- `o_mem_req` rises exactly one cycle after miss is seen; falls the edge after ack.
- Reset values: state IDLE, all valid=0, `o_mem_req`=0, `o_mem_addr`=0. With valid cleared, `o_stall`=1 and `o_instr`=0 immediately after reset.
- Reset mid-refill: request dropped at once; a later ack is ignored (state IDLE).

## Configuration
- `ICACHE_FLUSH_EN`: when defined, adds input `i_flush` (1 bit). `i_flush`=1 clears all valid bits at the next edge; if an ack writes in the same edge, flush wins (line left invalid); FSM state and `o_mem_req` are not affected. When undefined, port absent; valid bits clear only on reset.

## Test plan
- Reset, `i_pc`=0x0 → `o_stall`=1, `o_instr`=0; next cycle `o_mem_req`=1, `o_mem_addr`=0x0; ack with 0x2408_0005 → following cycle `o_stall`=0, `o_instr`=0x2408_0005.
- Fill pc 0x0..0xF (16 lines), then replay 0x0..0xF → no stall, `o_mem_req` never rises, correct data each cycle.
- Conflict: pc 0x03 filled, then pc 0x13 → miss, refill overwrites line 3; return to 0x03 → miss again.
- Ack delayed 5 cycles → `o_mem_req`, `o_mem_addr` stable, `o_stall`=1 all 5 cycles; stray ack while IDLE → no line written.
- `i_pc` 0x20 → 0x40 during WAIT → line 0 written with tag of 0x20, then new miss request for 0x40.
- `ICACHE_FLUSH_EN`: fill 0x5, assert `i_flush` in ack cycle of 0x6 refill → both 0x5 and 0x6 miss afterward; async reset during WAIT → `o_mem_req`=0 immediately.
